mem32_arbiter: RTL and testbench
================================

MEM32_ARBITER -- requirements
Module: mem32_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, selects arbitration: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0, req1  input  1 each  word-access request from requester 0 / 1.
REQ-005 wr0, wr1  input  1 each  access type: 1 = write, 0 = read; sampled with the request.
REQ-006 addr0, addr1  input  2 each  word address, range 0..3.
REQ-007 wdata0, wdata1  input  32 each  write word.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse when the request is accepted.
REQ-009 done0, done1  output  1 each  one-cycle pulse when the access completes.
REQ-010 rdata0, rdata1  output  32 each  read word, held until the next read completion for that requester.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 mem_we, mem_re  output  1 each  byte-memory write / read strobes.
REQ-013 mem_addr  output  4  byte address.
REQ-014 mem_wdata  output  8  write byte.
REQ-015 mem_rdata  input  8  read byte, valid in the cycle after mem_re is high (1-cycle latency).

Function
REQ-016 The FSM has four states: IDLE, XFER, WAIT and DONE; reset forces IDLE.
REQ-017 In IDLE, any sampled req moves the FSM to XFER at the next edge, with the winner's wr, addr and wdata latched.
- gnt of the winner is high for exactly the first XFER cycle.
REQ-018 A request is not accepted in any state other than IDLE; requesters hold req until gnt, and a req dropped before gnt is ignored.
REQ-019 Round-robin (RR_EN=1): on simultaneous req0 and req1, grant goes to the requester not granted last; the last-granted flag resets to 1, so requester 0 wins first.
REQ-020 A single requester is granted regardless of the last-granted flag.
REQ-021 XFER lasts exactly 4 cycles with byte counter k = 0..3.
- mem_addr = {addr, k}.
- Byte k carries word bits [8k+7:8k] (little-endian).
REQ-022 Write access: mem_we=1 and mem_wdata=byte k in each XFER cycle, then DONE.
REQ-023 Read access: mem_re=1 in each XFER cycle.
- mem_rdata is captured into byte k-1 during XFER cycles k=1..3.
- The final byte is captured in one WAIT cycle, then DONE.
REQ-024 DONE lasts one cycle: done of the owner is pulsed, rdata of the owner is updated on a read, then IDLE.
REQ-025 Latency from the grant cycle G to the done cycle: write = G+4, read = G+5.
- The next grant is no earlier than the cycle after DONE.
REQ-026 mem_we and mem_re are never high together, and are both 0 in IDLE, WAIT and DONE.
REQ-027 Word address 3 maps to bytes 12..15; there is no wrap beyond byte 15.
REQ-028 Only the owner's gnt and done ever pulse; the other requester's outputs stay 0.
REQ-029 Changes to wr, addr or wdata after gnt have no effect on the access in progress.

Reset
REQ-030 With rst=1 at an edge, the following take effect at that edge:
- state = IDLE, k = 0, last-granted = 1;
- gnt0, gnt1, done0, done1, busy, mem_we, mem_re = 0;
- mem_addr = 0, mem_wdata = 0;
- rdata0, rdata1 = 0.
REQ-031 Reset mid-access aborts the access: no further memory strobes and no done pulse.
- After reset is released, a held req is granted as a fresh request.

Verification
REQ-032 Req0 writes 0x302DAF60 to word 0 -> gnt0 pulse; mem_we on bytes 0..3 with data 60, AF, 2D, 30; done0 at G+4.
REQ-033 Req1 reads word 0 (behavioural byte memory) -> rdata1 = 0x302DAF60 at done1, G+5; rdata0 unchanged.
REQ-034 req0 and req1 both held continuously after reset, RR_EN=1 -> grant order 0, 1, 0, 1; no cycle with both gnt high.
REQ-035 Same stimulus with RR_EN=0 -> requester 0 granted on every arbitration.
REQ-036 Write 0x735E05D2 to word 3 -> mem_addr 12..15, data D2, 05, 5E, 73; read back returns 0x735E05D2.
REQ-037 Assert rst for 1 cycle at the second XFER cycle of a write -> outputs at reset values next cycle, bytes 2..3 not written, no done; held req re-granted after rst falls.

Source files
------------

// File: rtl/mem32_arbiter.sv
// mem32_arbiter: two-requester 32-bit word arbiter over a byte-wide memory (req/wr/addr/wdata in, gnt/done/rdata out, mem_* byte port)
module mem32_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic        mem_we,
  output logic        mem_re,
  output logic [3:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] k, addr_q;
  logic owner, last, wr_q, win, xfer;
  logic [31:0] wdata_q;
  logic [23:0] rbuf;
  assign win = (req0 && req1) ? (RR_EN != 0) && !last : !req0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? ((req0 || req1) ? XFER : IDLE) :
              state == XFER ? (k == 2'd3 ? (wr_q ? DONE : WAIT) : XFER) :
              state == WAIT ? DONE : IDLE;
    xfer = state == XFER;
    busy = state != IDLE;
    mem_we = xfer && wr_q;
    mem_re = xfer && !wr_q;
    mem_addr = xfer ? {addr_q, k} : 4'd0;
    mem_wdata = mem_we ? wdata_q[{k, 3'b000} +: 8] : 8'd0;
    gnt0 = xfer && k == 2'd0 && !owner;
    gnt1 = xfer && k == 2'd0 && owner;
    done0 = state == DONE && !owner;
    done1 = state == DONE && owner;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= 2'd0;
      last <= 1'b1;
      owner <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= 2'd0;
      wdata_q <= 32'd0;
      rbuf <= 24'd0;
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        owner <= win;
        last <= win;
        wr_q <= win ? wr1 : wr0;
        addr_q <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      k <= xfer ? k + 2'd1 : 2'd0;
      if (mem_re && k != 2'd0) rbuf[{k - 2'd1, 3'b000} +: 8] <= mem_rdata;
      if (state == WAIT && !owner) rdata0 <= {mem_rdata, rbuf};
      if (state == WAIT && owner) rdata1 <= {mem_rdata, rbuf};
    end
  end
endmodule

// File: tb/tb_mem32_arbiter.sv
// tb_mem32_arbiter: scoreboard bench for mem32_arbiter with a word-level reference model and byte memories
module tb_mem32_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic gnt0, gnt1, done0, done1, busy, mem_we, mem_re;
  logic [31:0] rdata0, rdata1;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = 8'd0;
  logic gnt0_f, gnt1_f, done0_f, done1_f, busy_f, mem_we_f, mem_re_f;
  logic [31:0] rdata0_f, rdata1_f;
  logic [3:0] mem_addr_f;
  logic [7:0] mem_wdata_f, mem_rdata_f = 8'd0;
  logic [7:0] bmem [16] = '{default: 8'h00};
  logic [7:0] bmem_f [16] = '{default: 8'h00};
  logic [7:0] rmem [16] = '{default: 8'h00};
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0;
  typedef struct {bit own; int due; bit wr; logic [31:0] rd;} exp_t;
  exp_t sb [$];
  exp_t e;
  bit m_busy = 0, m_last = 1, m_own = 0, m_wr = 0, w;
  int m_off = 0, m_lat = 0;
  logic [1:0] m_addr = 2'd0;
  logic [31:0] m_wd = 32'd0, m_rd = 32'd0, x_rd0 = 32'd0, x_rd1 = 32'd0, e0, e1;
  logic [16:0] ev;

  mem32_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  mem32_arbiter #(.RR_EN(0)) dut_f (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_f), .gnt1(gnt1_f), .done0(done0_f), .done1(done1_f),
    .rdata0(rdata0_f), .rdata1(rdata1_f), .busy(busy_f), .mem_we(mem_we_f), .mem_re(mem_re_f),
    .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) bmem[mem_addr] <= mem_wdata;
    mem_rdata <= bmem[mem_addr];
    if (mem_we_f) bmem_f[mem_addr_f] <= mem_wdata_f;
    mem_rdata_f <= bmem_f[mem_addr_f];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // reference model: one access at a time, tracked as an offset from its grant cycle
  always @(negedge clk) begin
    if (m_busy && m_off < 4)
      ev = {m_off == 0 && !m_own, m_off == 0 && m_own, 1'b1, m_wr, !m_wr, m_addr, 2'(m_off),
            m_wr ? m_wd[8*m_off +: 8] : 8'h00};
    else
      ev = {2'b00, m_busy, 14'h0};
    e0 = (m_busy && m_off == m_lat && !m_wr && !m_own) ? m_rd : x_rd0;
    e1 = (m_busy && m_off == m_lat && !m_wr && m_own) ? m_rd : x_rd1;
    if (cyc > 0) begin
      check("cycle_outputs", {gnt0, gnt1, busy, mem_we, mem_re, mem_addr, mem_wdata}, ev);
      check("rdata", {rdata0, rdata1}, {e0, e1});
      check("fp_exclusive", {gnt0_f && gnt1_f, mem_we_f && mem_re_f, done0_f && done1_f}, 0);
    end
    if (m_busy && m_off < 4 && m_wr) rmem[{m_addr, 2'(m_off)}] = m_wd[8*m_off +: 8];
    if (rst) begin
      m_busy = 0;
      m_last = 1;
      x_rd0 = 0;
      x_rd1 = 0;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else if (m_busy) begin
      if (m_off == m_lat) begin
        m_busy = 0;
        if (!m_wr && !m_own) x_rd0 = m_rd;
        if (!m_wr && m_own) x_rd1 = m_rd;
      end else m_off++;
    end else if (req0 || req1) begin
      w = (req0 && req1) ? !m_last : req1;
      m_last = w;
      m_own = w;
      m_wr = w ? wr1 : wr0;
      m_addr = w ? addr1 : addr0;
      m_wd = w ? wdata1 : wdata0;
      m_rd = {rmem[{m_addr, 2'd3}], rmem[{m_addr, 2'd2}], rmem[{m_addr, 2'd1}], rmem[{m_addr, 2'd0}]};
      m_lat = m_wr ? 4 : 5;
      m_off = 0;
      m_busy = 1;
      sb.push_back('{w, cyc + 1 + m_lat, m_wr, m_rd});
    end
  end

  // completion monitor
  always @(negedge clk) begin
    if (cyc > 0 && (done0 || done1)) begin
      n_done++;
      if (sb.size() == 0) check("done_unexpected", {done1, done0}, 0);
      else begin
        e = sb.pop_front();
        check("done_who", {done1, done0}, e.own ? 2'b10 : 2'b01);
        check("done_cycle", cyc, e.due);
        if (!e.wr) check("done_rdata", e.own ? rdata1 : rdata0, e.rd);
      end
    end
  end

  task automatic access(input bit who, input bit wr, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int g = -1, t = 0;
    rd = '0;
    lat = -1;
    @(posedge clk); #1;
    if (who) begin req1 = 1; wr1 = wr; addr1 = a; wdata1 = d; end
    else begin req0 = 1; wr0 = wr; addr0 = a; wdata0 = d; end
    while (g < 0 && t < 50) begin
      @(negedge clk);
      if (who ? gnt1 : gnt0) g = cyc;
      t++;
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    wr0 = ~wr0; wr1 = ~wr1; addr0 = addr0 + 2'd1; addr1 = addr1 + 2'd1;
    wdata0 = $urandom; wdata1 = $urandom;
    t = 0;
    while (lat < 0 && t < 50) begin
      @(negedge clk);
      if (who ? done1 : done0) begin lat = cyc - g; rd = who ? rdata1 : rdata0; end
      t++;
    end
    check("access_timeout", {g < 0, lat < 0}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, t, ng, fp0, fp1;
    logic [3:0] order;
    bit g0, g1;
    repeat (2) @(negedge clk);
    check("reset_ctl", {gnt0, gnt1, done0, done1, busy, mem_we, mem_re, mem_addr, mem_wdata}, 0);
    check("reset_rdata", {rdata0, rdata1}, 0);
    @(posedge clk); #1 rst = 0;
    access(0, 1, 2'd0, 32'h302DAF60, rd, lat);
    check("wr_latency", lat, 4);
    check("wr_bytes_w0", {bmem[3], bmem[2], bmem[1], bmem[0]}, 32'h302DAF60);
    access(1, 0, 2'd0, 32'h0, rd, lat);
    check("rd_latency", lat, 5);
    check("rd_data_w0", rd, 32'h302DAF60);
    check("rdata0_hold", rdata0, 0);
    access(0, 1, 2'd3, 32'h735E05D2, rd, lat);
    check("wr_bytes_w3", {bmem[15], bmem[14], bmem[13], bmem[12]}, 32'h735E05D2);
    access(0, 0, 2'd3, 32'h0, rd, lat);
    check("rd_data_w3", rd, 32'h735E05D2);
    access(1, 1, 2'd2, 32'h11223344, rd, lat);
    // reset during the second XFER cycle of a write
    @(posedge clk); #1;
    req0 = 1; wr0 = 1; addr0 = 2'd2; wdata0 = 32'hAABBCCDD;
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt0 && t < 20);
    check("rst_pre_gnt", gnt0, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_mid_ctl", {gnt0, gnt1, done0, done1, busy, mem_we, mem_re, mem_addr, mem_wdata}, 0);
    check("rst_mid_rdata", {rdata0, rdata1}, 0);
    check("rst_mid_bytes", {bmem[11], bmem[10], bmem[9], bmem[8]}, 32'h1122CCDD);
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt0 && !done0 && t < 20);
    check("rst_regrant", {gnt0, done0}, 2'b10);
    @(posedge clk); #1 req0 = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!done0 && t < 20);
    check("rst_rewrite", {bmem[11], bmem[10], bmem[9], bmem[8]}, 32'hAABBCCDD);
    // both requesters held continuously
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1; addr0 = 2'd0; addr1 = 2'd1;
    wdata0 = $urandom; wdata1 = $urandom;
    ng = 0; fp0 = 0; fp1 = 0; t = 0; order = 4'h0;
    while (ng < 4 && t < 100) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin order[ng] = gnt1; ng++; end
      fp0 += int'(gnt0_f);
      fp1 += int'(gnt1_f);
      t++;
    end
    check("rr_grants", ng, 4);
    check("rr_order", order, 4'b1010);
    check("fp_gnt1_count", fp1, 0);
    check("fp_gnt0_enough", fp0 >= 3, 1);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    repeat (8) @(negedge clk);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      if (req0 && g0) begin req0 = 0; wr0 = 1'($urandom); addr0 = 2'($urandom); wdata0 = $urandom; end
      else if (req0 && $urandom_range(0, 39) == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; wr0 = 1'($urandom); addr0 = 2'($urandom); wdata0 = $urandom;
      end
      if (req1 && g1) begin req1 = 0; wr1 = 1'($urandom); addr1 = 2'($urandom); wdata1 = $urandom; end
      else if (req1 && $urandom_range(0, 39) == 0) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; wr1 = 1'($urandom); addr1 = 2'($urandom); wdata1 = $urandom;
      end
    end
    @(posedge clk); #1;
    rst = 0; req0 = 0; req1 = 0;
    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("activity", n_done > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
